data_merge: RTL and testbench

- Receive-side counterpart of the ping-pong data switch. Rebuilds one frame stream from two AXI-Stream ping-pong channels.
- Takes PP_GROUP packets from IN1, then PP_GROUP packets from IN2, and alternates this way until FRAME_SIZE bytes have been forwarded.
- Sits downstream of the two ping-pong processing paths and feeds the single frame consumer.
- Checks packet and frame framing. Flags errors and resynchronises at frame boundaries.

---
 rtl/data_sw_pkg.sv | 25 ++
 rtl/axis_out_reg.sv | 38 +++
 rtl/data_merge.sv | 168 ++++++++++++++++
 tb/tb_data_merge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sw_pkg.sv
// Types and helpers shared by the ping-pong data switch and its merge counterpart.
package data_sw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN1 = 2'd1,
    ST_RUN2 = 2'd2
  } sw_state_t;

  localparam int DW_DEFAULT     = 512;
  localparam int BYTES_PER_BEAT = DW_DEFAULT / 8;

  // Widest TKEEP the popcount helper accepts; narrower keeps are zero-extended.
  localparam int KEEP_MAX = 128;

  function automatic logic [31:0] popcount(input logic [KEEP_MAX-1:0] keep);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      cnt = cnt + {31'd0, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single-stage AXI-Stream register slice; upstream ready passes through from downstream.
module axis_out_reg #(
  parameter int DW = 512
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [DW-1:0]   up_data,
  input  logic [DW/8-1:0] up_keep,
  input  logic            up_last,
  input  logic            up_valid,
  output logic            up_ready,
  output logic [DW-1:0]   dn_data,
  output logic [DW/8-1:0] dn_keep,
  output logic            dn_last,
  output logic            dn_valid,
  input  logic            dn_ready
);

  // A new beat may enter whenever the held one is empty or leaving this cycle.
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dn_data  <= '0;
      dn_keep  <= '0;
      dn_last  <= 1'b0;
      dn_valid <= 1'b0;
    end else if (up_valid && up_ready) begin
      dn_data  <= up_data;
      dn_keep  <= up_keep;
      dn_last  <= up_last;
      dn_valid <= 1'b1;
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_merge.sv
// Rebuilds one frame stream from the ping/pong AXI-Stream channels, checking
// packet and frame framing and resynchronising to IN1 at every frame boundary.
module data_merge
  import data_sw_pkg::*;
#(
  parameter int DW = BYTES_PER_BEAT * 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     FRAME_SIZE,
  input  logic [31:0]     PACKET_SIZE,
  input  logic [31:0]     PP_GROUP,
  input  logic [DW-1:0]   AXIS_IN1_TDATA,
  input  logic            AXIS_IN1_TVALID,
  output logic            AXIS_IN1_TREADY,
  input  logic [DW/8-1:0] AXIS_IN1_TKEEP,
  input  logic            AXIS_IN1_TLAST,
  input  logic [DW-1:0]   AXIS_IN2_TDATA,
  input  logic            AXIS_IN2_TVALID,
  output logic            AXIS_IN2_TREADY,
  input  logic [DW/8-1:0] AXIS_IN2_TKEEP,
  input  logic            AXIS_IN2_TLAST,
  output logic [DW-1:0]   AXIS_OUT_TDATA,
  output logic            AXIS_OUT_TVALID,
  input  logic            AXIS_OUT_TREADY,
  output logic [DW/8-1:0] AXIS_OUT_TKEEP,
  output logic            AXIS_OUT_TLAST,
  output logic            FRAME_DONE,
  output logic            ERR
);

  localparam int KW = DW / 8;

  sw_state_t state;

  logic [31:0] frame_rem;
  logic [31:0] pkt_rem;
  logic [31:0] grp_cnt;
  logic [31:0] pkt_size;
  logic [31:0] grp_size;
  logic [31:0] grp_next;
  logic [31:0] n_bytes;

  logic [DW-1:0]       sel_data;
  logic [KW-1:0]       sel_keep;
  logic                sel_last;
  logic                sel_valid;
  logic [KEEP_MAX-1:0] keep_ext;

  logic running;
  logic slice_ready;
  logic accept;
  logic overrun;
  logic pkt_full;
  logic frame_full;
  logic frame_end;
  logic beat_err;

  assign running = (state == ST_RUN1) || (state == ST_RUN2);

  // Only the channel owning the current group is offered ready.
  assign AXIS_IN1_TREADY = (state == ST_RUN1) && slice_ready;
  assign AXIS_IN2_TREADY = (state == ST_RUN2) && slice_ready;

  always_comb begin
    if (state == ST_RUN2) begin
      sel_data  = AXIS_IN2_TDATA;
      sel_keep  = AXIS_IN2_TKEEP;
      sel_last  = AXIS_IN2_TLAST;
      sel_valid = AXIS_IN2_TVALID;
    end else begin
      sel_data  = AXIS_IN1_TDATA;
      sel_keep  = AXIS_IN1_TKEEP;
      sel_last  = AXIS_IN1_TLAST;
      sel_valid = AXIS_IN1_TVALID;
    end
  end

  always_comb begin
    keep_ext         = '0;
    keep_ext[KW-1:0] = sel_keep;
  end

  assign n_bytes    = popcount(keep_ext);
  assign accept     = sel_valid && running && slice_ready;
  assign grp_next   = grp_cnt + 32'd1;

  // A beat is legal only if it fits both budgets and its TLAST agrees with
  // whichever budget it exhausts; a short final packet ends on the frame budget.
  assign overrun    = (n_bytes > frame_rem) || (n_bytes > pkt_rem);
  assign pkt_full   = (pkt_rem == n_bytes);
  assign frame_full = (frame_rem == n_bytes);
  assign frame_end  = sel_last && frame_full;
  assign beat_err   = overrun
                   || (sel_last && !pkt_full && !frame_full)
                   || (!sel_last && (pkt_full || frame_full));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      frame_rem  <= '0;
      pkt_rem    <= '0;
      grp_cnt    <= '0;
      pkt_size   <= '0;
      grp_size   <= '0;
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
      case (state)
        ST_IDLE: begin
          frame_rem <= FRAME_SIZE;
          pkt_rem   <= PACKET_SIZE;
          pkt_size  <= PACKET_SIZE;
          grp_size  <= (PP_GROUP == 32'd0) ? 32'd1 : PP_GROUP;
          grp_cnt   <= '0;
          if ((FRAME_SIZE != 32'd0) && (PACKET_SIZE != 32'd0)) begin
            state <= ST_RUN1;
          end
        end
        ST_RUN1, ST_RUN2: begin
          if (accept) begin
            if (beat_err) begin
              ERR   <= 1'b1;
              state <= ST_IDLE;
            end else if (frame_end) begin
              FRAME_DONE <= 1'b1;
              frame_rem  <= '0;
              state      <= ST_IDLE;
            end else begin
              frame_rem <= frame_rem - n_bytes;
              pkt_rem   <= pkt_rem - n_bytes;
              if (sel_last) begin
                pkt_rem <= pkt_size;
                if (grp_next == grp_size) begin
                  grp_cnt <= '0;
                  state   <= (state == ST_RUN1) ? ST_RUN2 : ST_RUN1;
                end else begin
                  grp_cnt <= grp_next;
                end
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axis_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk      (clk),
    .resetn   (resetn),
    .up_data  (sel_data),
    .up_keep  (sel_keep),
    .up_last  (frame_end || beat_err),
    .up_valid (sel_valid && running),
    .up_ready (slice_ready),
    .dn_data  (AXIS_OUT_TDATA),
    .dn_keep  (AXIS_OUT_TKEEP),
    .dn_last  (AXIS_OUT_TLAST),
    .dn_valid (AXIS_OUT_TVALID),
    .dn_ready (AXIS_OUT_TREADY)
  );

endmodule

// File: tb/tb_data_merge.sv
// Bench for data_merge: directed frame table, randomized frames and reset/idle corner sequences.
module tb_data_merge;

  localparam int DW = 512;
  localparam int KW = DW / 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [31:0]   FRAME_SIZE, PACKET_SIZE, PP_GROUP;
  logic [DW-1:0] AXIS_IN1_TDATA, AXIS_IN2_TDATA, AXIS_OUT_TDATA;
  logic [KW-1:0] AXIS_IN1_TKEEP, AXIS_IN2_TKEEP, AXIS_OUT_TKEEP;
  logic AXIS_IN1_TVALID, AXIS_IN1_TREADY, AXIS_IN1_TLAST;
  logic AXIS_IN2_TVALID, AXIS_IN2_TREADY, AXIS_IN2_TLAST;
  logic AXIS_OUT_TVALID, AXIS_OUT_TREADY, AXIS_OUT_TLAST;
  logic FRAME_DONE, ERR;

  data_merge #(.DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .FRAME_SIZE(FRAME_SIZE), .PACKET_SIZE(PACKET_SIZE), .PP_GROUP(PP_GROUP),
    .AXIS_IN1_TDATA(AXIS_IN1_TDATA), .AXIS_IN1_TVALID(AXIS_IN1_TVALID), .AXIS_IN1_TREADY(AXIS_IN1_TREADY),
    .AXIS_IN1_TKEEP(AXIS_IN1_TKEEP), .AXIS_IN1_TLAST(AXIS_IN1_TLAST),
    .AXIS_IN2_TDATA(AXIS_IN2_TDATA), .AXIS_IN2_TVALID(AXIS_IN2_TVALID), .AXIS_IN2_TREADY(AXIS_IN2_TREADY),
    .AXIS_IN2_TKEEP(AXIS_IN2_TKEEP), .AXIS_IN2_TLAST(AXIS_IN2_TLAST),
    .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID), .AXIS_OUT_TREADY(AXIS_OUT_TREADY),
    .AXIS_OUT_TKEEP(AXIS_OUT_TKEEP), .AXIS_OUT_TLAST(AXIS_OUT_TLAST),
    .FRAME_DONE(FRAME_DONE), .ERR(ERR)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    bit            ch;
  } beat_t;

  // kind: 0 clean, 1 early TLAST, 2 missing TLAST, 3 overrun on final beat
  typedef struct {
    int frame; int pkt; int grp; int stall; int kind; int sel;
    int exp_beats; int exp_err; int exp_done;
  } vec_t;

  beat_t q1[$], q2[$], expq[$], frm[$];
  vec_t  vecs[9];

  int n_tests = 0;
  int n_fail  = 0;
  int stall_mode = 0;
  int err_seen, done_seen, out_seen, overlap;
  bit prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [KW-1:0] prev_keep;
  logic          prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: observe outputs, drive inputs at negedge, then book the handshakes
  // that will complete at the following posedge.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (prev_stall) begin
      n_tests++;
      if (!(AXIS_OUT_TVALID && AXIS_OUT_TDATA === prev_data && AXIS_OUT_TKEEP === prev_keep
            && AXIS_OUT_TLAST === prev_last)) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%0b keep=%h last=%0b, expected held keep=%h last=%0b",
                 AXIS_OUT_TVALID, AXIS_OUT_TKEEP, AXIS_OUT_TLAST, prev_keep, prev_last);
      end
    end
    if (ERR) begin
      err_seen++;
      check("err_with_last_beat", {62'd0, AXIS_OUT_TVALID, AXIS_OUT_TLAST}, 64'd3);
    end
    if (FRAME_DONE) begin
      done_seen++;
      check("done_with_last_beat", {62'd0, AXIS_OUT_TVALID, AXIS_OUT_TLAST}, 64'd3);
    end
    case (stall_mode)
      0:       AXIS_OUT_TREADY = 1'b1;
      1:       AXIS_OUT_TREADY = !AXIS_OUT_TREADY;
      default: AXIS_OUT_TREADY = ($urandom_range(0, 1) == 1);
    endcase
    AXIS_IN1_TVALID = (q1.size() > 0);
    if (q1.size() > 0) begin
      AXIS_IN1_TDATA = q1[0].data; AXIS_IN1_TKEEP = q1[0].keep; AXIS_IN1_TLAST = q1[0].last;
    end
    AXIS_IN2_TVALID = (q2.size() > 0);
    if (q2.size() > 0) begin
      AXIS_IN2_TDATA = q2[0].data; AXIS_IN2_TKEEP = q2[0].keep; AXIS_IN2_TLAST = q2[0].last;
    end
    #1;
    if (AXIS_IN1_TREADY && AXIS_IN2_TREADY) overlap++;
    if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
      out_seen++;
      n_tests++;
      if (expq.size() == 0) begin
        n_fail++;
        $display("FAIL extra_beat: got beat keep=%h last=%0b, expected no beat", AXIS_OUT_TKEEP, AXIS_OUT_TLAST);
      end else begin
        e = expq[0];
        expq.delete(0);
        if (AXIS_OUT_TDATA !== e.data || AXIS_OUT_TKEEP !== e.keep || AXIS_OUT_TLAST !== e.last) begin
          n_fail++;
          $display("FAIL out_beat%0d: got data=%h keep=%h last=%0b, expected data=%h keep=%h last=%0b",
                   out_seen, AXIS_OUT_TDATA[63:0], AXIS_OUT_TKEEP, AXIS_OUT_TLAST,
                   e.data[63:0], e.keep, e.last);
        end
      end
    end
    if (AXIS_IN1_TVALID && AXIS_IN1_TREADY) q1.delete(0);
    if (AXIS_IN2_TVALID && AXIS_IN2_TREADY) q2.delete(0);
    prev_stall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
    prev_data  = AXIS_OUT_TDATA;
    prev_keep  = AXIS_OUT_TKEEP;
    prev_last  = AXIS_OUT_TLAST;
  endtask

  // Reference stream: packets of PACKET bytes (final one short), groups of
  // PP_GROUP packets alternating IN1/IN2 starting on IN1.
  task automatic build_frame(input int f, input int p, input int g);
    int npk, gg, bytes, nb, rem;
    beat_t bt;
    frm.delete();
    gg  = (g == 0) ? 1 : g;
    npk = (f + p - 1) / p;
    for (int k = 0; k < npk; k++) begin
      bytes = (k == npk - 1) ? f - (npk - 1) * p : p;
      nb    = (bytes + KW - 1) / KW;
      for (int b = 0; b < nb; b++) begin
        for (int w = 0; w < DW / 32; w++) bt.data[w*32 +: 32] = $urandom;
        rem     = bytes - KW * b;
        bt.keep = '1;
        if (rem < KW) bt.keep = (64'd1 << rem) - 64'd1;
        bt.last = (b == nb - 1);
        bt.ch   = (((k / gg) % 2) == 1);
        frm.push_back(bt);
      end
    end
  endtask

  // Corrupt the stream; the merge must stop on the corrupted beat.
  task automatic inject(input int kind, input int sel, output int eff);
    int idx, sz, i;
    beat_t t;
    sz = frm.size();
    idx = -1;
    eff = kind;
    if (kind == 3 && frm[sz-1].keep == '1) eff = 2;
    if (eff == 1) begin
      for (int j = 0; j < sz; j++) begin
        i = (sel + j) % sz;
        if (!frm[i].last) begin idx = i; break; end
      end
      if (idx < 0) eff = 2;
    end
    if (eff == 2) begin
      for (int j = 0; j < sz; j++) begin
        i = (sel + j) % sz;
        if (frm[i].last) begin idx = i; break; end
      end
    end
    if (eff == 3) idx = sz - 1;
    if (eff != 0) begin
      t = frm[idx];
      if (eff == 1) t.last = 1'b1;
      if (eff == 2) t.last = 1'b0;
      if (eff == 3) t.keep = '1;
      frm[idx] = t;
      while (frm.size() > idx + 1) frm.delete(frm.size() - 1);
    end
  endtask

  task automatic flush();
    q1.delete(); q2.delete(); expq.delete();
    AXIS_IN1_TVALID = 1'b0; AXIS_IN2_TVALID = 1'b0;
    FRAME_SIZE = 32'd0;
    prev_stall = 1'b0;
  endtask

  task automatic load_frame(input int f, input int p, input int g);
    beat_t t;
    for (int i = 0; i < frm.size(); i++) begin
      if (frm[i].ch) q2.push_back(frm[i]);
      else q1.push_back(frm[i]);
      t = frm[i];
      t.last = (i == frm.size() - 1);
      expq.push_back(t);
    end
    err_seen = 0; done_seen = 0; out_seen = 0; overlap = 0;
    PACKET_SIZE = p; PP_GROUP = g; FRAME_SIZE = f;
  endtask

  task automatic run_frame(input int id, input int f, input int p, input int g, input int stall,
                           input int exp_beats, input int exp_err, input int exp_done);
    int cyc;
    stall_mode = stall;
    load_frame(f, p, g);
    cyc = 0;
    while (cyc < 3000 && (expq.size() > 0 || q1.size() > 0 || q2.size() > 0)) begin
      step();
      if (q1.size() == 0 && q2.size() == 0) FRAME_SIZE = 32'd0;
      cyc++;
    end
    check($sformatf("f%0d_pending_at_timeout", id), expq.size() + q1.size() + q2.size(), 0);
    if (cyc >= 3000) begin
      flush();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      prev_stall = 1'b0;
    end
    repeat (3) step();
    check($sformatf("f%0d_beats", id), out_seen, exp_beats);
    check($sformatf("f%0d_err_pulses", id), err_seen, exp_err);
    check($sformatf("f%0d_done_pulses", id), done_seen, exp_done);
    check($sformatf("f%0d_ready_overlap", id), overlap, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int eff, f, p, g, npk, kind, rdy_cnt;

    //            frame  pkt grp stall kind sel beats err done
    vecs[0] = '{1024, 256, 2, 0, 0, 0, 16, 0, 1};
    vecs[1] = '{1024, 256, 2, 1, 0, 0, 16, 0, 1};
    vecs[2] = '{ 320, 128, 1, 0, 0, 0,  5, 0, 1};
    vecs[3] = '{1024, 256, 2, 0, 1, 1,  2, 1, 0};
    vecs[4] = '{ 512, 128, 0, 0, 0, 0,  8, 0, 1};
    vecs[5] = '{ 300, 128, 1, 0, 3, 0,  5, 1, 0};
    vecs[6] = '{ 512, 256, 1, 2, 2, 0,  4, 1, 0};
    vecs[7] = '{ 100, 100, 1, 2, 0, 0,  2, 0, 1};
    vecs[8] = '{  64,  64, 3, 0, 0, 0,  1, 0, 1};

    resetn = 1'b0;
    FRAME_SIZE = 0; PACKET_SIZE = 0; PP_GROUP = 0;
    AXIS_IN1_TVALID = 0; AXIS_IN1_TDATA = '0; AXIS_IN1_TKEEP = '0; AXIS_IN1_TLAST = 0;
    AXIS_IN2_TVALID = 0; AXIS_IN2_TDATA = '0; AXIS_IN2_TKEEP = '0; AXIS_IN2_TLAST = 0;
    AXIS_OUT_TREADY = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", AXIS_OUT_TVALID, 0);
    check("rst_out_data_nonzero", {63'd0, |AXIS_OUT_TDATA}, 0);
    check("rst_out_keep", AXIS_OUT_TKEEP, 0);
    check("rst_out_last", AXIS_OUT_TLAST, 0);
    check("rst_pulses", {62'd0, FRAME_DONE, ERR}, 0);
    check("rst_in_ready", {62'd0, AXIS_IN1_TREADY, AXIS_IN2_TREADY}, 0);
    resetn = 1'b1;

    // PACKET_SIZE=0 keeps the merge idle even with data offered
    build_frame(64, 64, 1);
    q1.push_back(frm[0]);
    PACKET_SIZE = 0; PP_GROUP = 1; FRAME_SIZE = 256;
    rdy_cnt = 0;
    repeat (6) begin
      step();
      if (AXIS_IN1_TREADY || AXIS_IN2_TREADY) rdy_cnt++;
    end
    check("idle_pkt0_ready_cycles", rdy_cnt, 0);
    check("idle_pkt0_beat_held", q1.size(), 1);
    flush();

    for (int i = 0; i < 9; i++) begin
      build_frame(vecs[i].frame, vecs[i].pkt, vecs[i].grp);
      inject(vecs[i].kind, vecs[i].sel, eff);
      run_frame(i, vecs[i].frame, vecs[i].pkt, vecs[i].grp, vecs[i].stall,
                vecs[i].exp_beats, vecs[i].exp_err, vecs[i].exp_done);
    end

    for (int i = 0; i < 40; i++) begin
      p    = $urandom_range(1, 200);
      npk  = $urandom_range(1, 6);
      f    = p * (npk - 1) + $urandom_range(1, p);
      g    = $urandom_range(0, 3);
      kind = $urandom_range(0, 5);
      kind = (kind <= 2) ? 0 : kind - 2;
      build_frame(f, p, g);
      inject(kind, $urandom_range(0, 31), eff);
      run_frame(100 + i, f, p, g, $urandom_range(0, 2), frm.size(),
                (eff != 0) ? 1 : 0, (eff == 0) ? 1 : 0);
    end

    // Reset in the middle of a frame, then a fresh frame
    stall_mode = 0;
    build_frame(1024, 256, 2);
    load_frame(1024, 256, 2);
    repeat (6) step();
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", AXIS_OUT_TVALID, 0);
    check("midrst_in_ready", {62'd0, AXIS_IN1_TREADY, AXIS_IN2_TREADY}, 0);
    resetn = 1'b1;
    flush();
    build_frame(1024, 256, 2);
    run_frame(200, 1024, 256, 2, 0, 16, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
